// File: rtl/mem_write_monitor.sv
// Pass/fail/hang checker for a core's data-memory write bus.
// The verdict is latched until reset, and the module also keeps write and cycle counters.
module mem_write_monitor #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned WATCH_LO       = 90,
    parameter int unsigned WATCH_HI       = 120,
    parameter int unsigned PASS_ADR       = 100,
    parameter int unsigned PASS_DATA      = 25,
    parameter int unsigned IGNORE_ADR     = 96,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 MemWrite,
    input  logic [WIDTH-1:0]     DataAdr,
    input  logic [WIDTH-1:0]     WriteData,
    output logic                 Done,
    output logic                 Pass,
    output logic                 Fail,
    output logic                 Timeout,
    output logic [WIDTH-1:0]     FailAdr,
    output logic [WIDTH-1:0]     FailData,
    output logic [CNT_WIDTH-1:0] WriteCount,
    output logic [CNT_WIDTH-1:0] CycleCount
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic                 TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_WIDTH-1:0] TO_LAST =
        CNT_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    if (WATCH_LO >= WATCH_HI) begin : g_chk_window
        $error("mem_write_monitor: WATCH_LO must be below WATCH_HI");
    end
    if ((PASS_ADR <= WATCH_LO) || (PASS_ADR >= WATCH_HI)) begin : g_chk_pass_adr
        $error("mem_write_monitor: PASS_ADR must lie strictly inside the watch window");
    end
    if ((CNT_WIDTH < 32) && (64'(TIMEOUT_CYCLES) > (64'd1 << CNT_WIDTH))) begin : g_chk_timeout
        $error("mem_write_monitor: TIMEOUT_CYCLES does not fit the counter width");
    end

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic                  fail_q, fail_d;
    logic                  timeout_q, timeout_d;
    logic [WIDTH-1:0]      fail_adr_q, fail_adr_d;
    logic [WIDTH-1:0]      fail_data_q, fail_data_d;
    logic [CNT_WIDTH-1:0]  write_cnt_q, write_cnt_d;
    logic [CNT_WIDTH-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic                  in_win;

    // Next-state, capture and counters; terminal states hold everything.
    always_comb begin
        state_d     = state_q;
        fail_adr_d  = fail_adr_q;
        fail_data_d = fail_data_q;
        write_cnt_d = write_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        in_win      = MemWrite && (DataAdr > WIDTH'(WATCH_LO)) && (DataAdr < WIDTH'(WATCH_HI));

        if (state_q == ST_RUN) begin
            if (cycle_cnt_q != CNT_MAX) cycle_cnt_d = cycle_cnt_q + CNT_WIDTH'(1);
            if (in_win && (write_cnt_q != CNT_MAX)) write_cnt_d = write_cnt_q + CNT_WIDTH'(1);

            if (in_win && (DataAdr == WIDTH'(PASS_ADR)) && (WriteData == WIDTH'(PASS_DATA))) begin
                state_d = ST_PASS;
            end else if (in_win && (DataAdr != WIDTH'(IGNORE_ADR))) begin
                state_d     = ST_FAIL;
                fail_adr_d  = DataAdr;
                fail_data_d = WriteData;
            end else if (in_win) begin
                state_d = ST_RUN;
            end else if (TO_EN && (cycle_cnt_q == TO_LAST)) begin
                state_d = ST_TIMEOUT;
            end
        end

        done_d    = (state_d != ST_RUN);
        pass_d    = (state_d == ST_PASS);
        fail_d    = (state_d == ST_FAIL);
        timeout_d = (state_d == ST_TIMEOUT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            fail_adr_q  <= '0;
            fail_data_q <= '0;
            write_cnt_q <= '0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            timeout_q   <= timeout_d;
            fail_adr_q  <= fail_adr_d;
            fail_data_q <= fail_data_d;
            write_cnt_q <= write_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign Done       = done_q;
    assign Pass       = pass_q;
    assign Fail       = fail_q;
    assign Timeout    = timeout_q;
    assign FailAdr    = fail_adr_q;
    assign FailData   = fail_data_q;
    assign WriteCount = write_cnt_q;
    assign CycleCount = cycle_cnt_q;

endmodule

// File: tb/tb_mem_write_monitor.sv
// Scoreboard bench for mem_write_monitor: default, short-timeout and narrow-counter instances.
module tb_mem_write_monitor;

    localparam int unsigned W   = 32;
    localparam int unsigned CW  = 16;
    localparam int unsigned SCW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mem_write = 1'b0;
    logic [W-1:0]  data_adr = '0;
    logic [W-1:0]  write_data = '0;

    logic          done, pass, fail, timeout;
    logic [W-1:0]  fail_adr, fail_data;
    logic [CW-1:0] write_cnt, cycle_cnt;

    logic          to_done, to_pass, to_fail, to_timeout;
    logic [W-1:0]  to_fail_adr, to_fail_data;
    logic [CW-1:0] to_write_cnt, to_cycle_cnt;

    logic           sat_done, sat_pass, sat_fail, sat_timeout;
    logic [W-1:0]   sat_fail_adr, sat_fail_data;
    logic [SCW-1:0] sat_write_cnt, sat_cycle_cnt;

    always #5 clk = ~clk;

    mem_write_monitor dut (
        .clk(clk), .reset(reset), .MemWrite(mem_write), .DataAdr(data_adr), .WriteData(write_data),
        .Done(done), .Pass(pass), .Fail(fail), .Timeout(timeout),
        .FailAdr(fail_adr), .FailData(fail_data), .WriteCount(write_cnt), .CycleCount(cycle_cnt)
    );

    mem_write_monitor #(.TIMEOUT_CYCLES(50)) dut_to (
        .clk(clk), .reset(reset), .MemWrite(mem_write), .DataAdr(data_adr), .WriteData(write_data),
        .Done(to_done), .Pass(to_pass), .Fail(to_fail), .Timeout(to_timeout),
        .FailAdr(to_fail_adr), .FailData(to_fail_data), .WriteCount(to_write_cnt), .CycleCount(to_cycle_cnt)
    );

    mem_write_monitor #(.CNT_WIDTH(SCW), .TIMEOUT_CYCLES(0)) dut_sat (
        .clk(clk), .reset(reset), .MemWrite(mem_write), .DataAdr(data_adr), .WriteData(write_data),
        .Done(sat_done), .Pass(sat_pass), .Fail(sat_fail), .Timeout(sat_timeout),
        .FailAdr(sat_fail_adr), .FailData(sat_fail_data), .WriteCount(sat_write_cnt), .CycleCount(sat_cycle_cnt)
    );

    typedef struct {
        logic          pass, fail, timeout, done;
        logic [W-1:0]  fadr, fdata;
        logic [CW-1:0] wc, cc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model of the default instance: 0=run 1=pass 2=fail 3=timeout
    int            m_state = 0;
    logic [W-1:0]  m_fadr  = '0;
    logic [W-1:0]  m_fdata = '0;
    logic [CW-1:0] m_wc    = '0;
    logic [CW-1:0] m_cc    = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle, push the model's expectation, then pop and compare after the edge.
    task automatic step(input logic rst, input logic we, input logic [W-1:0] adr, input logic [W-1:0] dat);
        exp_t e;
        logic win;
        logic [CW-1:0] cc_old;
        reset = rst; mem_write = we; data_adr = adr; write_data = dat;
        win    = we && (adr > 90) && (adr < 120);
        cc_old = m_cc;
        if (rst) begin
            m_state = 0; m_fadr = '0; m_fdata = '0; m_wc = '0; m_cc = '0;
        end else if (m_state == 0) begin
            if (m_cc != 16'hFFFF) m_cc = m_cc + 16'd1;
            if (win && m_wc != 16'hFFFF) m_wc = m_wc + 16'd1;
            if (win && adr == 100 && dat == 25) m_state = 1;
            else if (win && adr != 96) begin
                m_state = 2; m_fadr = adr; m_fdata = dat;
            end else if (!win && cc_old == 16'd999) m_state = 3;
        end
        e.pass = (m_state == 1); e.fail = (m_state == 2); e.timeout = (m_state == 3);
        e.done = (m_state != 0); e.fadr = m_fadr; e.fdata = m_fdata; e.wc = m_wc; e.cc = m_cc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        if (exp_q.size() == 0) begin
            check("sb_empty", 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check("sb_pass", 64'(pass), 64'(e.pass));
            check("sb_fail", 64'(fail), 64'(e.fail));
            check("sb_timeout", 64'(timeout), 64'(e.timeout));
            check("sb_done", 64'(done), 64'(e.done));
            check("sb_fail_adr", 64'(fail_adr), 64'(e.fadr));
            check("sb_fail_data", 64'(fail_data), 64'(e.fdata));
            check("sb_write_cnt", 64'(write_cnt), 64'(e.wc));
            check("sb_cycle_cnt", 64'(cycle_cnt), 64'(e.cc));
        end
    endtask

    initial begin
        // Reset, tolerated scratch write, then the pass write
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_cycle_cnt", 64'(cycle_cnt), 64'd0);
        step(0, 1, 96, 7);
        step(0, 1, 100, 25);
        check("t1_pass", 64'(pass), 64'd1);
        check("t1_done", 64'(done), 64'd1);
        check("t1_fail", 64'(fail), 64'd0);
        check("t1_write_cnt", 64'(write_cnt), 64'd2);
        for (int i = 0; i < 20; i++) begin
            step(0, (i == 5), 104, 0);
            check("t1_pass_hold", 64'(pass), 64'd1);
        end

        // Bad write, then absorbing FAIL
        step(1, 0, 0, 0);
        step(0, 1, 104, 32'hDEAD);
        check("t2_fail", 64'(fail), 64'd1);
        check("t2_fail_adr", 64'(fail_adr), 64'd104);
        check("t2_fail_data", 64'(fail_data), 64'hDEAD);
        step(0, 1, 100, 25);
        check("t2_no_pass", 64'(pass), 64'd0);
        check("t2_fail_hold", 64'(fail), 64'd1);

        // Reset out of FAIL, then pass
        step(1, 0, 0, 0);
        check("t5_fail_clr", 64'(fail), 64'd0);
        check("t5_done_clr", 64'(done), 64'd0);
        check("t5_fail_adr_clr", 64'(fail_adr), 64'd0);
        check("t5_write_cnt_clr", 64'(write_cnt), 64'd0);
        step(0, 1, 100, 25);
        check("t5_pass", 64'(pass), 64'd1);

        // Window boundaries, strobe-low pass pattern, then wrong pass data
        step(1, 0, 0, 0);
        step(0, 1, 90, 1);
        step(0, 1, 120, 2);
        step(0, 0, 100, 25);
        check("t3_run", 64'(done), 64'd0);
        check("t3_write_cnt", 64'(write_cnt), 64'd0);
        step(0, 1, 100, 24);
        check("t3_fail", 64'(fail), 64'd1);
        check("t3_fail_adr", 64'(fail_adr), 64'd100);
        check("t3_fail_data", 64'(fail_data), 64'd24);

        // Timeout after 50 idle edges on the short-timeout instance
        step(1, 0, 0, 0);
        for (int i = 0; i < 49; i++) step(0, 0, 0, 0);
        check("t4_not_yet", 64'(to_timeout), 64'd0);
        step(0, 0, 0, 0);
        check("t4_timeout", 64'(to_timeout), 64'd1);
        check("t4_done", 64'(to_done), 64'd1);
        check("t4_cycle_cnt", 64'(to_cycle_cnt), 64'd50);
        step(0, 1, 100, 25);
        check("t4_absorb", 64'(to_pass), 64'd0);
        check("t4_cycle_hold", 64'(to_cycle_cnt), 64'd50);

        // Pass write on the expiry edge beats the timeout
        step(1, 0, 0, 0);
        for (int i = 0; i < 49; i++) step(0, 0, 0, 0);
        step(0, 1, 100, 25);
        check("t4b_pass", 64'(to_pass), 64'd1);
        check("t4b_no_timeout", 64'(to_timeout), 64'd0);
        check("t4b_write_cnt", 64'(to_write_cnt), 64'd1);

        // Counter saturation on the 4-bit instance
        step(1, 0, 0, 0);
        for (int i = 0; i < 30; i++) step(0, 1, 96, W'(i));
        check("t6_write_sat", 64'(sat_write_cnt), 64'd15);
        check("t6_cycle_sat", 64'(sat_cycle_cnt), 64'd15);
        check("t6_run", 64'(sat_done), 64'd0);
        check("t6_no_flags", 64'({sat_pass, sat_fail, sat_timeout}), 64'd0);
        check("t6_fail_adr", 64'(sat_fail_adr | sat_fail_data), 64'd0);
        check("t6_to_fail_data", 64'(to_fail_adr | to_fail_data), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
